// File: rtl/video_pkg.sv
// Shared video timing types and mode constants for the display path.
package video_pkg;

    localparam int COORD_W = 13;

    typedef struct packed {
        logic [COORD_W-1:0] h_res;
        logic [COORD_W-1:0] h_fp;
        logic [COORD_W-1:0] h_sync;
        logic [COORD_W-1:0] h_bp;
        logic               h_pol;
        logic [COORD_W-1:0] v_res;
        logic [COORD_W-1:0] v_fp;
        logic [COORD_W-1:0] v_sync;
        logic [COORD_W-1:0] v_bp;
        logic               v_pol;
    } video_timing_t;

    localparam video_timing_t MODE_VGA_640x480 = '{
        h_res: 13'd640,  h_fp: 13'd16,  h_sync: 13'd96,  h_bp: 13'd48,  h_pol: 1'b0,
        v_res: 13'd480,  v_fp: 13'd10,  v_sync: 13'd2,   v_bp: 13'd33,  v_pol: 1'b0
    };

    localparam video_timing_t MODE_XGA_1024x768 = '{
        h_res: 13'd1024, h_fp: 13'd24,  h_sync: 13'd136, h_bp: 13'd160, h_pol: 1'b0,
        v_res: 13'd768,  v_fp: 13'd3,   v_sync: 13'd6,   v_bp: 13'd29,  v_pol: 1'b0
    };

    localparam video_timing_t MODE_HD_1280x720 = '{
        h_res: 13'd1280, h_fp: 13'd110, h_sync: 13'd40,  h_bp: 13'd220, h_pol: 1'b1,
        v_res: 13'd720,  v_fp: 13'd5,   v_sync: 13'd5,   v_bp: 13'd20,  v_pol: 1'b1
    };

endpackage

// File: rtl/sync_axis.sv
// One timing axis: wrapping counter with sync and active flags decoded from the next count.
// Latency: flags registered alongside the count, so they describe the presented count; holds when inc is low.
module sync_axis
    import video_pkg::*;
#(
    parameter int RES  = 1024,
    parameter int FP   = 24,
    parameter int SYNC = 136,
    parameter int BP   = 160,
    parameter int POL  = 0
)(
    input  logic               clk_pix,
    input  logic               rst_n,
    input  logic               inc,
    output logic [COORD_W-1:0] cnt,
    output logic               wrap,
    output logic               sync,
    output logic               act
);

    localparam int TOTAL = RES + FP + SYNC + BP;
    localparam logic [COORD_W-1:0] LAST     = COORD_W'(TOTAL - 1);
    localparam logic [COORD_W-1:0] ACT_END  = COORD_W'(RES);
    localparam logic [COORD_W-1:0] SYNC_ON  = COORD_W'(RES + FP);
    localparam logic [COORD_W-1:0] SYNC_OFF = COORD_W'(RES + FP + SYNC);
    localparam logic SYNC_ASSERT = (POL != 0);

    logic [COORD_W-1:0] cnt_nxt;

    assign wrap    = (cnt == LAST);
    assign cnt_nxt = wrap ? '0 : cnt + COORD_W'(1);

    // Decode from cnt_nxt so the registered flags line up with the registered count.
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= LAST;
            sync <= !SYNC_ASSERT;
            act  <= 1'b0;
        end else if (inc) begin
            cnt  <= cnt_nxt;
            act  <= (cnt_nxt < ACT_END);
            sync <= ((cnt_nxt >= SYNC_ON) && (cnt_nxt < SYNC_OFF)) ? SYNC_ASSERT : !SYNC_ASSERT;
        end
    end

endmodule

// File: rtl/sync_gen.sv
// Pixel-timing generator: h/v counters, syncs, active flag, line/frame strobes and frame counter.
// Latency: zero cycles from counter to decoded flags; ce low holds all state and suppresses strobes.
module sync_gen
    import video_pkg::*;
#(
    parameter int H_RES  = 1024,
    parameter int H_FP   = 24,
    parameter int H_SYNC = 136,
    parameter int H_BP   = 160,
    parameter int V_RES  = 768,
    parameter int V_FP   = 3,
    parameter int V_SYNC = 6,
    parameter int V_BP   = 29,
    parameter int H_POL  = 0,
    parameter int V_POL  = 0
)(
    input  logic               clk_pix,
    input  logic               rst_n,
    input  logic               ce,
    output logic [COORD_W-1:0] h,
    output logic [COORD_W-1:0] v,
    output logic               hsync,
    output logic               vsync,
    output logic               active,
    output logic               line_start,
    output logic               frame_start,
    output logic [15:0]        frame_count
);

    localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 8191 || V_TOTAL > 8191) begin : g_bad_mode
        $error("sync_gen: mode totals exceed the 13-bit coordinate range");
    end

    // Async assert, synchronised release.
    logic [1:0] rst_sr;
    logic       rst_int;

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) rst_sr <= 2'b00;
        else        rst_sr <= {rst_sr[0], 1'b1};
    end
    assign rst_int = rst_sr[1];

    logic h_wrap, v_wrap, h_act, v_act;

    sync_axis #(.RES(H_RES), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_POL)) u_h_axis (
        .clk_pix (clk_pix),
        .rst_n   (rst_int),
        .inc     (ce),
        .cnt     (h),
        .wrap    (h_wrap),
        .sync    (hsync),
        .act     (h_act)
    );

    sync_axis #(.RES(V_RES), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_POL)) u_v_axis (
        .clk_pix (clk_pix),
        .rst_n   (rst_int),
        .inc     (ce & h_wrap),
        .cnt     (v),
        .wrap    (v_wrap),
        .sync    (vsync),
        .act     (v_act)
    );

    assign active = h_act & v_act;

    // A wrap on this edge means the next presented position is column 0 / origin.
    always_ff @(posedge clk_pix or negedge rst_int) begin
        if (!rst_int) begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= 16'd0;
        end else begin
            line_start  <= ce & h_wrap;
            frame_start <= ce & h_wrap & v_wrap;
            if (ce && h_wrap && v_wrap)
                frame_count <= frame_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_sync_gen.sv
// Scoreboard bench: default XGA instance plus a tiny mode with positive syncs, shared random ce/rst_n.
module tb_sync_gen;
    import video_pkg::*;

    localparam video_timing_t MX = '{
        h_res: 13'd1024, h_fp: 13'd24, h_sync: 13'd136, h_bp: 13'd160, h_pol: 1'b0,
        v_res: 13'd768,  v_fp: 13'd3,  v_sync: 13'd6,   v_bp: 13'd29,  v_pol: 1'b0
    };
    localparam video_timing_t MS = '{
        h_res: 13'd16, h_fp: 13'd2, h_sync: 13'd3, h_bp: 13'd4, h_pol: 1'b1,
        v_res: 13'd6,  v_fp: 13'd1, v_sync: 13'd2, v_bp: 13'd1, v_pol: 1'b1
    };

    typedef struct packed {
        logic [12:0] h;
        logic [12:0] v;
        logic        hs;
        logic        vs;
        logic        act;
        logic        ls;
        logic        fs;
        logic [15:0] fc;
    } out_t;

    typedef struct {
        int p;       // linear position within the frame, h = p % H_TOTAL, v = p / H_TOTAL
        int frames;
        bit ls;
        bit fs;
        int dead;    // edges still swallowed by the reset release synchroniser
    } mst_t;

    logic clk_pix = 1'b0;
    logic rst_n;
    logic ce;

    logic [12:0] hx, vx, hs_, vs_;
    logic        hsx, vsx, actx, lsx, fsx, hss, vss, acts, lss, fss;
    logic [15:0] fcx, fcs;

    always #5 clk_pix = ~clk_pix;

    sync_gen u_dut_x (
        .clk_pix(clk_pix), .rst_n(rst_n), .ce(ce),
        .h(hx), .v(vx), .hsync(hsx), .vsync(vsx), .active(actx),
        .line_start(lsx), .frame_start(fsx), .frame_count(fcx)
    );

    sync_gen #(
        .H_RES(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_RES(6),  .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1),  .V_POL(1)
    ) u_dut_s (
        .clk_pix(clk_pix), .rst_n(rst_n), .ce(ce),
        .h(hs_), .v(vs_), .hsync(hss), .vsync(vss), .active(acts),
        .line_start(lss), .frame_start(fss), .frame_count(fcs)
    );

    out_t out_x, out_s;
    assign out_x = {hx, vx, hsx, vsx, actx, lsx, fsx, fcx};
    assign out_s = {hs_, vs_, hss, vss, acts, lss, fss, fcs};

    function automatic int htot(video_timing_t m);
        return int'(m.h_res) + int'(m.h_fp) + int'(m.h_sync) + int'(m.h_bp);
    endfunction

    function automatic int vtot(video_timing_t m);
        return int'(m.v_res) + int'(m.v_fp) + int'(m.v_sync) + int'(m.v_bp);
    endfunction

    function automatic mst_t m_reset(video_timing_t m);
        mst_t s;
        s.p = htot(m) * vtot(m) - 1;
        s.frames = 0;
        s.ls = 0;
        s.fs = 0;
        s.dead = 2;
        return s;
    endfunction

    function automatic mst_t m_step(video_timing_t m, mst_t s, logic ce_i);
        mst_t n = s;
        n.ls = 0;
        n.fs = 0;
        if (s.dead > 0) begin
            n.dead = s.dead - 1;
        end else if (ce_i) begin
            n.p  = (s.p + 1) % (htot(m) * vtot(m));
            n.ls = ((n.p % htot(m)) == 0);
            n.fs = (n.p == 0);
            if (n.fs) n.frames = (s.frames + 1) % 65536;
        end
        return n;
    endfunction

    function automatic out_t m_out(video_timing_t m, mst_t s);
        out_t o;
        int hh, vv, hs0, vs0;
        hh  = s.p % htot(m);
        vv  = s.p / htot(m);
        hs0 = int'(m.h_res) + int'(m.h_fp);
        vs0 = int'(m.v_res) + int'(m.v_fp);
        o.h   = 13'(hh);
        o.v   = 13'(vv);
        o.hs  = (hh >= hs0 && hh < hs0 + int'(m.h_sync)) ? m.h_pol : ~m.h_pol;
        o.vs  = (vv >= vs0 && vv < vs0 + int'(m.v_sync)) ? m.v_pol : ~m.v_pol;
        o.act = (hh < int'(m.h_res)) && (vv < int'(m.v_res));
        o.ls  = s.ls;
        o.fs  = s.fs;
        o.fc  = 16'(s.frames);
        return o;
    endfunction

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input out_t got, input out_t exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s t=%0t got h=%0d v=%0d hs=%b vs=%b act=%b ls=%b fs=%b fc=%0d want h=%0d v=%0d hs=%b vs=%b act=%b ls=%b fs=%b fc=%0d",
                      name, $time, got.h, got.v, got.hs, got.vs, got.act, got.ls, got.fs, got.fc,
                      exp.h, exp.v, exp.hs, exp.vs, exp.act, exp.ls, exp.fs, exp.fc);
    endtask

    // Reference model and scoreboard queues
    mst_t sx, ss;
    out_t qx[$];
    out_t qs[$];
    bit   started = 0;

    initial begin
        sx = m_reset(MX);
        ss = m_reset(MS);
    end

    always @(posedge clk_pix) begin
        if (!rst_n) begin
            sx = m_reset(MX);
            ss = m_reset(MS);
        end else begin
            sx = m_step(MX, sx, ce);
            ss = m_step(MS, ss, ce);
        end
        qx.push_back(m_out(MX, sx));
        qs.push_back(m_out(MS, ss));
        started = 1;
    end

    // Async reset changes the outputs already expected for the current cycle.
    always @(negedge rst_n) begin
        sx = m_reset(MX);
        ss = m_reset(MS);
        if (qx.size() > 0) qx[qx.size()-1] = m_out(MX, sx);
        if (qs.size() > 0) qs[qs.size()-1] = m_out(MS, ss);
    end

    always @(negedge clk_pix) begin
        if (started) begin
            if (qx.size() == 0 || qs.size() == 0) begin
                n_chk++;
                $display("FAIL queue_empty t=%0t got qx=%0d qs=%0d entries want at least 1", $time, qx.size(), qs.size());
            end else begin
                check("xga", out_x, qx.pop_front());
                check("tiny", out_s, qs.pop_front());
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        ce    = 1'b0;
        repeat (5) @(posedge clk_pix);
        #2 ce = 1'b1;
        @(posedge clk_pix);
        #2 rst_n = 1'b1;

        // Full line sweep of the XGA instance
        repeat (1400) @(posedge clk_pix);

        for (int i = 0; i < 200; i++) begin
            @(posedge clk_pix);
            #2 ce = i[0];
        end

        for (int i = 0; i < 20000; i++) begin
            @(posedge clk_pix);
            #2 ce = ($urandom_range(0, 3) != 0);
            if (i == 9000 || $urandom_range(0, 2999) == 0) begin
                rst_n = 1'b0;
                #1;
                check("async_rst_xga", out_x, m_out(MX, m_reset(MX)));
                check("async_rst_tiny", out_s, m_out(MS, m_reset(MS)));
                repeat ($urandom_range(1, 4)) @(posedge clk_pix);
                #2 rst_n = 1'b1;
            end
        end

        ce = 1'b1;
        repeat (3000) @(posedge clk_pix);
        @(negedge clk_pix);
        @(negedge clk_pix);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sync_gen.md
# sync_gen

Pixel-timing generator for the SDL simulation and FPGA display path. It sits directly upstream of the pattern and drawing stages, which consume its `h`/`v` counters and `active` flag. It produces registered horizontal/vertical counters, sync pulses, the active-video flag, and per-line and per-frame strobes for one video mode selected by parameters. The default mode is XGA 1024x768@60.

## Interface
Parameters:
- `H_RES`, 1024: active pixels per line
- `H_FP`, 24: horizontal front porch, pixels
- `H_SYNC`, 136: hsync width, pixels
- `H_BP`, 160: horizontal back porch, pixels
- `V_RES`, 768: active lines per frame
- `V_FP`, 3: vertical front porch, lines
- `V_SYNC`, 6: vsync width, lines
- `V_BP`, 29: vertical back porch, lines
- `H_POL`, 0: hsync asserted level (0 = active-low)
- `V_POL`, 0: vsync asserted level

Ports:
- `clk_pix` in 1: pixel clock, sole clock
- `rst_n` in 1: asynchronous active-low reset
- `ce` in 1: pixel clock enable; when low, all state holds
- `h` out 13: horizontal position, 0..H_TOTAL-1
- `v` out 13: vertical position, 0..V_TOTAL-1
- `hsync` out 1: horizontal sync at level `H_POL` when asserted
- `vsync` out 1: vertical sync at level `V_POL` when asserted
- `active` out 1: high when `h < H_RES` and `v < V_RES`
- `line_start` out 1: one-cycle strobe when `h == 0`
- `frame_start` out 1: one-cycle strobe when `h == 0` and `v == 0`
- `frame_count` out 16: number of frames started since reset, wraps

## Operation
- Derived totals: `H_TOTAL = H_RES+H_FP+H_SYNC+H_BP` (default 1344) and `V_TOTAL` (default 806). Both must be ≤ 8191; elaboration fails otherwise.
- Each axis steps through phases ACTIVE → FRONT → SYNC → BACK → ACTIVE. The phase is derived from the counter by compare; no separate state register.
- Horizontal: on an enabled cycle, `h` increments. At `H_TOTAL-1`, `h` wraps to 0.
- Vertical: `v` increments only on an enabled cycle where `h == H_TOTAL-1`. At `V_TOTAL-1` it wraps to 0.
- hsync is asserted for `H_RES+H_FP ≤ h < H_RES+H_FP+H_SYNC`; default window 1048..1183.
- vsync is asserted for `V_RES+V_FP ≤ v < V_RES+V_FP+V_SYNC`; default window 771..776, spanning full lines.
- `frame_count` increments on the same edge that raises `frame_start`.
- `ce` low:
  - `h`, `v`, sync outputs, `active` and `frame_count` hold.
  - `line_start` and `frame_start` are forced low, so a held position never re-fires a strobe.
- All arithmetic is unsigned 13-bit. Compares use constants precomputed at elaboration.

## Timing
- Every output is registered and updated from the same edge, so `hsync`, `vsync`, `active` and both strobes always describe the `h`/`v` values presented in the same cycle.
- Downstream stages add their own latency.
- Reset (async assert, applied while `rst_n` is low):
  - `h = H_TOTAL-1`, `v = V_TOTAL-1`
  - `active = 0`, `hsync = !H_POL`, `vsync = !V_POL`
  - `line_start = 0`, `frame_start = 0`, `frame_count = 0`
- `rst_n` release is synchronised inside the block with a 2-flop deassert synchroniser. The first enabled edge after release presents `h = 0`, `v = 0`, `active = 1`, `line_start = 1`, `frame_start = 1`, `frame_count = 1`.
- Reset mid-frame aborts the current frame immediately. There is no partial-frame completion.
- Simultaneous horizontal and vertical wrap: at `h = H_TOTAL-1`, `v = V_TOTAL-1` with `ce` high, both counters go to 0 on one edge.
- Latency: zero cycles from the counter value to its decoded flags.

## Structure
- Shared package `video_pkg` holds:
  - a mode-timing struct `video_timing_t` (res, fp, sync, bp, pol per axis)
  - constants `MODE_VGA_640x480`, `MODE_XGA_1024x768`, `MODE_HD_1280x720`
  - the counter width constant `COORD_W = 13`
- Sub-module `sync_axis` (parameters RES/FP/SYNC/BP/POL; ports `clk_pix`, `rst_n`, `inc`, `cnt`, `wrap`, `sync`, `act`):
  - instantiated once per axis
  - the horizontal instance uses `inc = ce`
  - the vertical instance uses `inc = ce & h_wrap`
- The top-level block combines the axes into `active`, the strobes and `frame_count`.

## Test plan
- Reset: hold `rst_n = 0` for 5 cycles → `h = 1343`, `v = 805`, `hsync = vsync = 1`, `active = 0`, `frame_count = 0`. After release, the first enabled edge gives `h = 0`, `v = 0`, `frame_start = 1`, `frame_count = 1`.
- Horizontal sweep of line 0 with `ce = 1`:
  - `active` is high for `h` 0..1023
  - `hsync` is low for exactly 136 cycles, `h` 1048..1183
  - `line_start` is high only at `h = 0`
- Line and frame wrap:
  - at `h = 1343`, `v = 10` → next cycle `h = 0`, `v = 11`, `frame_start = 0`
  - at `h = 1343`, `v = 805` → next cycle `h = 0`, `v = 0`, `frame_start = 1`, `frame_count` increments
- Vsync and count: over a full frame, `vsync` is low for `v` 771..776 (6 × 1344 cycles). `frame_count` preset to 0xFFFF wraps to 0x0000.
- Clock enable: toggle `ce` 1/0 alternately → the counters advance every other cycle. With `ce` low at `h = 0`, the strobe drops and `h` holds at 0.
- Reset mid-frame: assert `rst_n = 0` at `h = 500`, `v = 300` → outputs take their reset values without waiting for an edge, and counting restarts at (0,0).
